// File: rtl/soc_pkg.sv
// Shared SoC definitions: datapath width, instruction
// memory base address and the imem controller states.
package soc_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] IMEM_BASE_ADDR = 32'h8000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// 1R1W word storage, no reset. Writes land on the rising edge.
// Ports: clock; we/waddr/wdata write port; raddr -> rdata read port.
module imem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data is sampled by the owner's register on the
  // same edge as any write, so a colliding write is seen
  // as old data (read-before-write).
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_sram.sv
// Instruction memory on the fetch IO bus: one outstanding read,
// fixed LATENCY, fault on misaligned/out-of-range, backdoor load.
// Ports: clock, reset; io_reqValid/io_addr request;
// io_respValid/io_rdata/io_respErr response; ld_* backdoor write.
module imem_sram
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_reqValid,
  input  logic [31:0]                    io_addr,
  output logic                           io_respValid,
  output logic [31:0]                    io_rdata,
  output logic                           io_respErr,
  input  logic                           ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_wdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  imem_state_t state;
  imem_state_t next_state;

  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          err_q;

  logic [31:0]   off;
  logic          req_fault;
  logic [AW-1:0] req_idx;
  logic          accept;
  logic          last;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   arr_rdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fault.
  assign off       = io_addr - BASE_ADDR;
  assign req_fault = (io_addr[1:0] != 2'b00) || (off >= SPAN);
  assign req_idx   = off[AW+1:2];

  assign accept = (state == IDLE) && io_reqValid;

  // With LATENCY=1 the read happens in the accept cycle
  // straight off the bus; otherwise from the captured copy.
  assign last = (LATENCY == 1) ? accept
              : ((state == BUSY) && (cnt == 4'd1));

  assign rd_idx = (state == IDLE) ? req_idx : idx_q;
  assign rd_err = (state == IDLE) ? req_fault : err_q;

  imem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_wdata),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (io_reqValid && (LATENCY > 1)) next_state = BUSY;
      BUSY: if (cnt == 4'd1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      io_respValid <= 1'b0;
      io_respErr   <= 1'b0;
      io_rdata     <= 32'h0;
    end else begin
      state <= next_state;
      if (accept) begin
        idx_q <= req_idx;
        err_q <= req_fault;
        cnt   <= LAT_M1;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      io_respValid <= last;
      io_respErr   <= last && rd_err;
      if (last) io_rdata <= rd_err ? 32'h0 : arr_rdata;
    end
  end

endmodule

// File: tb/tb_imem_sram.sv
// Directed bench for imem_sram: four instances with
// LATENCY 2, 1, 3 and 15 sharing clock, reset and loader.
module tb_imem_sram;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [31:0] ld_wdata;

  logic        req [4];
  logic [31:0] addr [4];
  logic        rv [4];
  logic [31:0] rd [4];
  logic        re [4];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
    imem_sram #(
      .BASE_ADDR   (32'h8000_0000),
      .DEPTH_WORDS (4096),
      .LATENCY     (L)
    ) dut (
      .clock        (clock),
      .reset        (reset),
      .io_reqValid  (req[g]),
      .io_addr      (addr[g]),
      .io_respValid (rv[g]),
      .io_rdata     (rd[g]),
      .io_respErr   (re[g]),
      .ld_we        (ld_we),
      .ld_addr      (ld_addr),
      .ld_wdata     (ld_wdata)
    );
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    ld_we    = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    step();
    ld_we    = 1'b0;
  endtask

  // Single LATENCY=2 fetch on instance 0, checked at T+1..T+3.
  task automatic fetch2(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic e);
    req[0]  = 1'b1;
    addr[0] = a;
    step();
    req[0]  = 1'b0;
    chk({tag, "_v1"}, 32'(rv[0]), 32'd0);
    step();
    chk({tag, "_v2"}, 32'(rv[0]), 32'd1);
    chk({tag, "_d"}, rd[0], d);
    chk({tag, "_e"}, 32'(re[0]), 32'(e));
    step();
    chk({tag, "_v3"}, 32'(rv[0]), 32'd0);
    chk({tag, "_e3"}, 32'(re[0]), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]  = 1'b0;
      addr[i] = '0;
    end
    step();
    step();
    chk("rst_v", 32'(rv[0]), 32'd0);
    chk("rst_d", rd[0], 32'h0);
    chk("rst_e", 32'(re[0]), 32'd0);
    reset = 1'b0;
    step();

    load(12'd0, 32'hDEAD_BEEF);
    load(12'd1, 32'h11);
    load(12'd2, 32'h22);
    load(12'd5, 32'hA);

    fetch2("basic", 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
    chk("basic_hold", rd[0], 32'hDEAD_BEEF);

    fetch2("misal", 32'h8000_0002, 32'h0, 1'b1);
    fetch2("range", 32'h8000_4000, 32'h0, 1'b1);
    fetch2("below", 32'h7FFF_FFFC, 32'h0, 1'b1);
    fetch2("lastw", 32'h8000_3FFC, 32'hX, 1'b0);

    // Back-to-back: second request in the first response cycle.
    req[0]  = 1'b1;
    addr[0] = 32'h8000_0004;
    step();
    req[0] = 1'b0;
    chk("b2b_v1", 32'(rv[0]), 32'd0);
    step();
    chk("b2b_v2", 32'(rv[0]), 32'd1);
    chk("b2b_d2", rd[0], 32'h11);
    req[0]  = 1'b1;
    addr[0] = 32'h8000_0008;
    step();
    req[0] = 1'b0;
    chk("b2b_v3", 32'(rv[0]), 32'd0);
    step();
    chk("b2b_v4", 32'(rv[0]), 32'd1);
    chk("b2b_d4", rd[0], 32'h22);
    step();
    chk("b2b_v5", 32'(rv[0]), 32'd0);

    // Latency sweep on instances 1 (L=1), 2 (L=3), 3 (L=15).
    for (int i = 1; i < 4; i++) begin
      automatic int lat = (i == 1) ? 1 : (i == 2) ? 3 : 15;
      req[i]  = 1'b1;
      addr[i] = 32'h8000_0000;
      step();
      req[i] = 1'b0;
      for (int c = 1; c <= lat + 2; c++) begin
        chk($sformatf("lat%0d_v%0d", lat, c), 32'(rv[i]),
            32'(c == lat));
        if (c == lat) chk($sformatf("lat%0d_d", lat), rd[i],
                          32'hDEAD_BEEF);
        step();
      end
    end

    // Collision: write word 5 on the read edge; stray request
    // while BUSY must be ignored.
    req[0]  = 1'b1;
    addr[0] = 32'h8000_0014;
    step();
    req[0]   = 1'b1;
    addr[0]  = 32'h8000_0000;
    ld_we    = 1'b1;
    ld_addr  = 12'd5;
    ld_wdata = 32'hB;
    step();
    req[0] = 1'b0;
    ld_we  = 1'b0;
    chk("col_v2", 32'(rv[0]), 32'd1);
    chk("col_d", rd[0], 32'hA);
    step();
    chk("col_v3", 32'(rv[0]), 32'd0);
    step();
    chk("col_v4", 32'(rv[0]), 32'd0);
    fetch2("col_new", 32'h8000_0014, 32'hB, 1'b0);

    // Reset mid-access on instance 2 (L=3).
    req[2]  = 1'b1;
    addr[2] = 32'h8000_0004;
    step();
    req[2] = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rstm_v", 32'(rv[2]), 32'd0);
    chk("rstm_d", rd[2], 32'h0);
    chk("rstm_e", 32'(re[2]), 32'd0);
    step();
    reset = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      chk($sformatf("rstm_quiet%0d", c), 32'(rv[2]), 32'd0);
      step();
    end
    req[2]  = 1'b1;
    addr[2] = 32'h8000_0000;
    step();
    req[2] = 1'b0;
    step();
    chk("rstm_r2", 32'(rv[2]), 32'd0);
    step();
    chk("rstm_r3", 32'(rv[2]), 32'd1);
    chk("rstm_mem", rd[2], 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_sram.md
Name: imem_sram

Overview:
- Instruction-memory target sitting directly on the fetch unit's IO bus; consumes `io_reqValid`/`io_addr` and produces `io_respValid`/`io_rdata`.
- Models a word-addressed on-chip SRAM with fixed, parameterised read latency.
- Supports exactly one outstanding read.
- Flags misaligned and out-of-range fetches with an error bit.
- Provides a backdoor write port for program preload by the SoC loader or the bench.

Parameters:
- `BASE_ADDR`, `32'h8000_0000`, byte address of word 0.
- `DEPTH_WORDS`, `4096`, number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, `2`, cycles from request acceptance to response; legal range 1..15.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_reqValid`  in  1  fetch request strobe.
- `io_addr`  in  32  byte address; sampled only on acceptance.
- `io_respValid`  out  1  one-cycle response pulse.
- `io_rdata`  out  32  read data; meaningful only while `io_respValid` is high.
- `io_respErr`  out  1  access fault; qualified by `io_respValid`.
- `ld_we`  in  1  backdoor write enable.
- `ld_addr`  in  $clog2(DEPTH_WORDS)  backdoor word index.
- `ld_wdata`  in  32  backdoor write data.

Behaviour:
- Reset is asynchronous and active-high; the fixed `clock`/`reset` pair is as stated under Ports.
- Reset values:
  - state = IDLE, counter = 0.
  - `io_respValid` = 0, `io_respErr` = 0, `io_rdata` = 32'h0.
  - Memory contents are NOT reset.
- States: IDLE, BUSY (single-bit enum).
- Acceptance:
  - A request is accepted in cycle T iff state = IDLE and `io_reqValid` = 1.
  - `io_addr` is captured into an address register.
  - The fault flag is computed and registered at acceptance.
- Fault conditions:
  - `io_addr[1:0]` != 0, OR
  - (`io_addr` − `BASE_ADDR`) ≥ `DEPTH_WORDS`*4, using unsigned 32-bit compare, so addresses below `BASE_ADDR` wrap and fault.
- Word index = (`io_addr` − `BASE_ADDR`) >> 2, truncated to $clog2(DEPTH_WORDS) bits.
- Latency and transitions:
  - `io_respValid` is high in exactly cycle T+`LATENCY`, for one cycle.
  - `LATENCY`=1: on acceptance, stay IDLE and register the response for the next cycle.
  - `LATENCY`>1: on acceptance, go to BUSY and load counter = `LATENCY`−1.
  - In BUSY, counter decrements each cycle. When counter = 1, the response is registered for the next cycle and state returns to IDLE.
- Response contents:
  - `io_rdata` = array[index] read on the final cycle before the response.
  - If faulted: `io_rdata` = 32'h0 and `io_respErr` = 1.
  - Otherwise `io_respErr` = 0.
  - `io_rdata` holds its last value after the pulse; `io_respErr` clears to 0 after the pulse.
- Back-to-back operation:
  - The controller is in IDLE during the response cycle, so a request presented in the same cycle `io_respValid` = 1 is accepted.
  - Sustained throughput is one fetch per `LATENCY` cycles.
- `io_reqValid` asserted while BUSY:
  - Ignored; no effect on the in-flight access, and no queuing.
  - Bench treats this as a protocol violation by the master, not an error here.
- Backdoor writes:
  - Write in any state; takes effect at the clock edge.
  - A write to the word being read on the same edge as the array read returns the OLD data (read-before-write).
  - A write to a different word has no interaction with the read.
- Reset mid-access: the pending response is discarded, and no `io_respValid` follows reset deassertion.

Decomposition:
- `soc_pkg`:
  - state enum typedef `imem_state_t` {IDLE, BUSY}.
  - `IMEM_BASE_ADDR` default.
  - `XLEN` = 32 constant.
- Sub-module `imem_array`: 1R1W synchronous storage, read-before-write, no reset.
- FSM, counter and fault logic live in `imem_sram`.

Test Plan:
- Basic read:
  - Stimulus: preload word 0 = 32'hDEAD_BEEF, `LATENCY`=2, request `io_addr` = 32'h8000_0000 at T.
  - Required: `io_respValid` = 1 only at T+2; `io_rdata` = 32'hDEAD_BEEF; `io_respErr` = 0.
- Misaligned and out-of-range faults:
  - Stimulus: request 32'h8000_0002, then 32'h8000_4000 (`DEPTH_WORDS`=4096), then 32'h7FFF_FFFC.
  - Required: each gives `io_respErr` = 1 and `io_rdata` = 0 at the normal latency.
- Back-to-back fetch:
  - Stimulus: preload words 1 and 2 = 32'h11, 32'h22; request 32'h8000_0004 at T; request 32'h8000_0008 in the T+2 response cycle.
  - Required: responses 32'h11 at T+2 and 32'h22 at T+4; no gap or drop.
- `LATENCY` sweep:
  - Stimulus: `LATENCY` = 1, 3, 15.
  - Required: pulse exactly at T+1, T+3 and T+15 respectively, each exactly one cycle wide.
- Read/write collision and ignored request:
  - Stimulus: word 5 = 32'hA; request 32'h8000_0014 (`LATENCY`=2); `ld_we` word 5 = 32'hB on the read edge; `io_reqValid` pulse at T+1.
  - Required: response 32'hA; only one response; a later read returns 32'hB.
- Reset mid-access:
  - Stimulus: assert `reset` at T+1 of a `LATENCY`=3 access, release at T+2.
  - Required: outputs zero immediately (async); no `io_respValid` through T+10; preloaded memory intact.
